// File: rtl/spi_readback_unit.sv
// SPI read-path companion: decodes read frames from the raw SPI pins
// and shifts the addressed control register out on cipo.
module spi_readback_unit #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  input  logic [7:0] reg_out_7_0,
  input  logic [7:0] reg_out_15_8,
  input  logic [7:0] reg_pwm_7_0,
  input  logic [7:0] reg_pwm_15_8,
  input  logic [7:0] reg_duty,
  output logic       cipo,
  output logic       cipo_oe,
  output logic [6:0] rd_addr,
  output logic       rd_done,
  output logic       rd_err
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    WAIT_CS
  } state_t;

  localparam logic [6:0] NR = 7'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] copi_q;
  logic [SYNC_STAGES-1:0] ncs_q;
  logic                   sclk_d;
  logic                   ncs_d;

  // Synchronizers are left out of reset so that a reset with ncs held
  // low never manufactures an ncs falling edge.
  always_ff @(posedge clk) begin
    sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
    copi_q <= {copi_q[SYNC_STAGES-2:0], copi};
    ncs_q  <= {ncs_q[SYNC_STAGES-2:0], ncs};
    sclk_d <= sclk_q[SYNC_STAGES-1];
    ncs_d  <= ncs_q[SYNC_STAGES-1];
  end

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic ncs_fall;
  logic ncs_rise;
  logic sclk_rise;
  logic sclk_fall;

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign copi_s    = copi_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_q[SYNC_STAGES-1];
  assign ncs_fall  = ncs_d & ~ncs_s;
  assign ncs_rise  = ~ncs_d & ncs_s;
  assign sclk_rise = ~ncs_s & sclk_s & ~sclk_d;
  assign sclk_fall = ~ncs_s & ~sclk_s & sclk_d;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] cmd;
  logic [7:0] shreg;
  logic [7:0] cmd_nxt;
  logic [7:0] snap;
  logic       in_range;

  assign cmd_nxt  = {cmd[6:0], copi_s};
  assign in_range = cmd_nxt[6:0] < NR;

  always_comb begin
    snap = 8'h00;
    unique case (cmd_nxt[6:0])
      7'd0:    snap = reg_out_7_0;
      7'd1:    snap = reg_out_15_8;
      7'd2:    snap = reg_pwm_7_0;
      7'd3:    snap = reg_pwm_15_8;
      7'd4:    snap = reg_duty;
      default: snap = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      cmd     <= 8'h00;
      shreg   <= 8'h00;
      cipo    <= 1'b0;
      cipo_oe <= 1'b0;
      rd_addr <= 7'd0;
      rd_done <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      rd_err  <= 1'b0;
      if (ncs_rise) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        cipo    <= 1'b0;
        cipo_oe <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ncs_fall) begin
              state   <= CMD;
              bit_cnt <= 3'd0;
              cmd     <= 8'h00;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd     <= cmd_nxt;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (cmd_nxt[7]) begin
                  state <= WAIT_CS;
                end else begin
                  rd_addr <= cmd_nxt[6:0];
                  shreg   <= in_range ? snap : 8'h00;
                  cipo    <= in_range ? snap[7] : 1'b0;
                  cipo_oe <= 1'b1;
                  rd_err  <= ~in_range;
                  state   <= DATA;
                end
              end
            end
          end
          DATA: begin
            // bit_cnt==0 masks the trailing fall of the command byte
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rd_done <= 1'b1;
                state   <= WAIT_CS;
              end
            end else if (sclk_fall && bit_cnt != 3'd0) begin
              shreg <= {shreg[6:0], 1'b0};
              cipo  <= shreg[6];
            end
          end
          WAIT_CS: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_readback_unit.sv
// Directed bench for spi_readback_unit: host-side SPI frames with
// hand-computed readback values.
module tb_spi_readback_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] reg_out_7_0 = 8'h11;
  logic [7:0] reg_out_15_8 = 8'h22;
  logic [7:0] reg_pwm_7_0 = 8'h33;
  logic [7:0] reg_pwm_15_8 = 8'h44;
  logic [7:0] reg_duty = 8'h80;
  logic       cipo;
  logic       cipo_oe;
  logic [6:0] rd_addr;
  logic       rd_done;
  logic       rd_err;

  int passed = 0;
  int total = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int oe_cnt = 0;

  spi_readback_unit #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
    .clk(clk),
    .rst(rst),
    .sclk(sclk),
    .copi(copi),
    .ncs(ncs),
    .reg_out_7_0(reg_out_7_0),
    .reg_out_15_8(reg_out_15_8),
    .reg_pwm_7_0(reg_pwm_7_0),
    .reg_pwm_15_8(reg_pwm_15_8),
    .reg_duty(reg_duty),
    .cipo(cipo),
    .cipo_oe(cipo_oe),
    .rd_addr(rd_addr),
    .rd_done(rd_done),
    .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_done) done_cnt++;
    if (rd_err) err_cnt++;
    if (cipo_oe) oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_mon();
    done_cnt = 0;
    err_cnt = 0;
    oe_cnt = 0;
  endtask

  // chg_at: bit index where reg_out_7_0 becomes 0xEE (-1 none)
  // rst_at: bit index before which rst pulses (-1 none)
  task automatic frame(input logic [7:0] c, input logic [7:0] w,
                       input int nbits, input int chg_at,
                       input int rst_at, output logic [7:0] rx);
    logic [15:0] bits;
    bits = {c, w};
    rx = 8'h00;
    ncs = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
      end
      if (i == chg_at) reg_out_7_0 = 8'hEE;
      copi = bits[15-i];
      wait_clk(8);
      if (i >= 8) rx = {rx[6:0], cipo};
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
    end
    wait_clk(8);
    ncs = 1'b1;
  endtask

  logic [7:0] rx;

  initial begin
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    chk("rst_cipo", 32'(cipo), 0);
    chk("rst_oe", 32'(cipo_oe), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_done", 32'(rd_done), 0);
    chk("rst_err", 32'(rd_err), 0);
    wait_clk(6);

    clr_mon();
    frame(8'h02, 8'h00, 16, -1, -1, rx);
    chk("rd2_data", 32'(rx), 32'h33);
    chk("rd2_addr", 32'(rd_addr), 2);
    chk("rd2_done", 32'(done_cnt), 1);
    chk("rd2_err", 32'(err_cnt), 0);
    wait_clk(10);
    chk("rd2_oe_off", 32'(cipo_oe), 0);
    chk("rd2_cipo_off", 32'(cipo), 0);

    clr_mon();
    frame(8'h81, 8'hAB, 16, -1, -1, rx);
    wait_clk(10);
    chk("wr_oe", 32'(oe_cnt), 0);
    chk("wr_done", 32'(done_cnt), 0);
    chk("wr_err", 32'(err_cnt), 0);

    clr_mon();
    frame(8'h04, 8'h00, 16, -1, -1, rx);
    wait_clk(10);
    chk("rd4_data", 32'(rx), 32'h80);
    chk("rd4_addr", 32'(rd_addr), 4);
    chk("rd4_done", 32'(done_cnt), 1);

    clr_mon();
    frame(8'h7F, 8'h00, 16, -1, -1, rx);
    wait_clk(10);
    chk("bad_data", 32'(rx), 0);
    chk("bad_addr", 32'(rd_addr), 32'h7F);
    chk("bad_err", 32'(err_cnt), 1);
    chk("bad_done", 32'(done_cnt), 1);

    clr_mon();
    frame(8'h00, 8'h00, 16, 10, -1, rx);
    wait_clk(10);
    chk("snap_data", 32'(rx), 32'h11);
    chk("snap_done", 32'(done_cnt), 1);
    reg_out_7_0 = 8'h11;

    clr_mon();
    frame(8'h01, 8'h00, 12, -1, -1, rx);
    chk("abort_oe_on", 32'(cipo_oe), 1);
    wait_clk(4);
    chk("abort_oe_off", 32'(cipo_oe), 0);
    chk("abort_done", 32'(done_cnt), 0);
    chk("abort_part", 32'(rx), 32'h02);
    wait_clk(10);

    clr_mon();
    frame(8'h01, 8'h00, 16, -1, -1, rx);
    wait_clk(10);
    chk("rd1_data", 32'(rx), 32'h22);
    chk("rd1_done", 32'(done_cnt), 1);

    clr_mon();
    frame(8'h02, 8'h00, 16, -1, 4, rx);
    wait_clk(10);
    chk("rstcmd_oe", 32'(oe_cnt), 0);
    chk("rstcmd_done", 32'(done_cnt), 0);
    chk("rstcmd_err", 32'(err_cnt), 0);
    chk("rstcmd_addr", 32'(rd_addr), 0);

    clr_mon();
    frame(8'h03, 8'h00, 16, -1, -1, rx);
    wait_clk(10);
    chk("rd3_data", 32'(rx), 32'h44);
    chk("rd3_addr", 32'(rd_addr), 3);
    chk("rd3_done", 32'(done_cnt), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
